// File: rtl/bus_rv32_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_rv32_arbiter_if
// Description : Requester-side and peripheral-side signals of the RV32 bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_rv32_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
);
    logic [NUM_MASTERS-1:0]            m_req_i;
    logic [NUM_MASTERS-1:0]            m_we_i;
    logic [NUM_MASTERS-1:0]            m_lock_i;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_address_i;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_i;
    logic [DATA_WIDTH-1:0]             m_data_o;
    logic [NUM_MASTERS-1:0]            m_ack_o;
    logic [NUM_MASTERS-1:0]            m_halt_o;
    logic [NUM_MASTERS-1:0]            grant_o;
    logic [ADDR_WIDTH-1:0]             s_address_o;
    logic                              s_we_o;
    logic [DATA_WIDTH-1:0]             s_data_o;
    logic [DATA_WIDTH-1:0]             s_data_i;

    // Arbiter view
    modport slave (
        input  m_req_i, m_we_i, m_lock_i, m_address_i, m_data_i, s_data_i,
        output m_data_o, m_ack_o, m_halt_o, grant_o, s_address_o, s_we_o, s_data_o
    );

    // Requester / peripheral environment view
    modport master (
        output m_req_i, m_we_i, m_lock_i, m_address_i, m_data_i, s_data_i,
        input  m_data_o, m_ack_o, m_halt_o, grant_o, s_address_o, s_we_o, s_data_o
    );
endinterface
`default_nettype wire

// File: rtl/bus_rv32_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_rv32_arbiter
// Description : Round-robin N-master arbiter for the RV32 peripheral bus with
//               programmable read latency. Define BUS_ARB_LOCK_EN to enable
//               bus locking by the last granted master.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_rv32_arbiter #(
    parameter int NUM_MASTERS  = 2,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  wire logic         clk_i,
    input  wire logic         reset_i,
    bus_rv32_arbiter_if.slave bus
);
    localparam int c_IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int c_CNT_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_IDX_W-1:0]     r_last;
    logic [c_IDX_W-1:0]     r_gnt_idx;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [ADDR_WIDTH-1:0]  r_s_addr;
    logic [DATA_WIDTH-1:0]  r_s_data;
    logic [DATA_WIDTH-1:0]  r_m_data;

    logic                   w_rr_vld;
    logic [c_IDX_W-1:0]     w_rr_win;
    logic [c_IDX_W-1:0]     w_rr_idx;
    logic                   w_sel_vld;
    logic [c_IDX_W-1:0]     w_sel_idx;
    logic                   w_s_we;
    logic [NUM_MASTERS-1:0] w_ack;

    // Scan from farthest to nearest so the nearest requester after r_last wins
    always_comb begin
        w_rr_vld = 1'b0;
        w_rr_win = '0;
        w_rr_idx = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            w_rr_idx = c_IDX_W'((int'(r_last) + k) % NUM_MASTERS);
            if (bus.m_req_i[w_rr_idx]) begin
                w_rr_vld = 1'b1;
                w_rr_win = w_rr_idx;
            end
        end
    end

`ifdef BUS_ARB_LOCK_EN
    logic               r_lock_vld;
    logic [c_IDX_W-1:0] r_lock_own;
    logic               w_lock_rel;

    always_comb begin
        w_sel_vld  = w_rr_vld;
        w_sel_idx  = w_rr_win;
        w_lock_rel = 1'b0;
        if (r_lock_vld) begin
            w_sel_vld  = bus.m_req_i[r_lock_own];
            w_sel_idx  = r_lock_own;
            w_lock_rel = !bus.m_req_i[r_lock_own] && !bus.m_lock_i[r_lock_own];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_lock_vld <= 1'b0;
            r_lock_own <= '0;
        end else if (r_state == ST_ACK) begin
            r_lock_vld <= bus.m_lock_i[r_gnt_idx];
            r_lock_own <= r_gnt_idx;
        end else if (r_state == ST_IDLE && w_lock_rel) begin
            r_lock_vld <= 1'b0;
        end
    end
`else
    logic w_unused_lock;
    assign w_unused_lock = |bus.m_lock_i;
    assign w_sel_vld     = w_rr_vld;
    assign w_sel_idx     = w_rr_win;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_we      = 1'b0;
        w_ack       = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_sel_vld) begin
                    w_state_nxt = bus.m_we_i[w_sel_idx] ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                w_s_we      = 1'b1;
                w_state_nxt = ST_ACK;
            end
            ST_READ: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                w_ack       = r_grant;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_last    <= c_IDX_W'(NUM_MASTERS - 1);
            r_gnt_idx <= '0;
            r_grant   <= '0;
            r_cnt     <= '0;
            r_s_addr  <= '0;
            r_s_data  <= '0;
            r_m_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_vld) begin
                        r_gnt_idx <= w_sel_idx;
                        r_grant   <= {{(NUM_MASTERS-1){1'b0}}, 1'b1} << w_sel_idx;
                        r_s_addr  <= bus.m_address_i[w_sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        r_s_data  <= bus.m_data_i[w_sel_idx*DATA_WIDTH +: DATA_WIDTH];
                        r_cnt     <= c_CNT_W'(READ_LATENCY - 1);
                    end
                end
                ST_READ: begin
                    if (r_cnt == '0) begin
                        r_m_data <= bus.s_data_i;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_ACK: begin
                    r_last  <= r_gnt_idx;
                    r_grant <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.grant_o     = r_grant;
    assign bus.s_address_o = r_s_addr;
    assign bus.s_data_o    = r_s_data;
    assign bus.s_we_o      = w_s_we;
    assign bus.m_data_o    = r_m_data;
    assign bus.m_ack_o     = w_ack;
    assign bus.m_halt_o    = bus.m_req_i & ~w_ack;

endmodule
`default_nettype wire

// File: tb/tb_bus_rv32_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_rv32_arbiter
// Description : Self-checking bench for bus_rv32_arbiter (2 masters, read latency 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_rv32_arbiter;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RL = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bus_rv32_arbiter_if #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    bus_rv32_arbiter #(
        .NUM_MASTERS (N),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .READ_LATENCY(RL)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a granted transfer lasts a fixed number of
    // cycles after arbitration (2 for a write, RL+1 for a read).
    bit             md_busy  = 1'b0;
    bit             md_we    = 1'b0;
    int             md_win   = 0;
    int             md_phase = 0;
    int             md_last  = N - 1;
    int             md_pick;
    int             md_dur;
    bit             md_lockv = 1'b0;
    int             md_lown  = 0;
    logic [AW-1:0]  md_addr  = '0;
    logic [DW-1:0]  md_wdata = '0;
    logic [DW-1:0]  md_rdata = '0;
    logic [N-1:0]   e_grant;
    logic [N-1:0]   e_ack;

    always @(negedge clk) begin
        if (rst) begin
            md_busy  = 1'b0;
            md_phase = 0;
            md_last  = N - 1;
            md_addr  = '0;
            md_wdata = '0;
            md_rdata = '0;
            md_lockv = 1'b0;
            md_lown  = 0;
        end
        md_dur  = md_we ? 2 : RL + 1;
        e_grant = md_busy ? N'(1 << md_win) : '0;
        e_ack   = (md_busy && md_phase == md_dur) ? e_grant : '0;
        chk("mon_grant", bus.grant_o, e_grant);
        chk("mon_ack", bus.m_ack_o, e_ack);
        chk("mon_halt", bus.m_halt_o, bus.m_req_i & ~e_ack);
        chk("mon_s_we", bus.s_we_o, (md_busy && md_we && md_phase == 1) ? 1 : 0);
        chk("mon_s_addr", bus.s_address_o, md_addr);
        chk("mon_s_data", bus.s_data_o, md_wdata);
        chk("mon_m_data", bus.m_data_o, md_rdata);
        if (!rst) begin
            if (!md_busy) begin
                md_pick = -1;
`ifdef BUS_ARB_LOCK_EN
                if (md_lockv) begin
                    if (bus.m_req_i[md_lown]) md_pick = md_lown;
                    else if (!bus.m_lock_i[md_lown]) md_lockv = 1'b0;
                end else
`endif
                for (int k = 1; k <= N; k++) begin
                    if (md_pick < 0 && bus.m_req_i[(md_last + k) % N]) md_pick = (md_last + k) % N;
                end
                if (md_pick >= 0) begin
                    md_busy  = 1'b1;
                    md_win   = md_pick;
                    md_phase = 1;
                    md_we    = bus.m_we_i[md_pick];
                    md_addr  = bus.m_address_i[md_pick*AW +: AW];
                    md_wdata = bus.m_data_i[md_pick*DW +: DW];
                end
            end else begin
                if (!md_we && md_phase == RL) md_rdata = bus.s_data_i;
                if (md_phase == md_dur) begin
                    md_busy = 1'b0;
                    md_last = md_win;
`ifdef BUS_ARB_LOCK_EN
                    md_lockv = bus.m_lock_i[md_win];
                    md_lown  = md_win;
`endif
                end else begin
                    md_phase++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_m(input int i, input bit req, input bit we, input bit lk,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.m_req_i[i]              = req;
        bus.m_we_i[i]               = we;
        bus.m_lock_i[i]             = lk;
        bus.m_address_i[i*AW +: AW] = a;
        bus.m_data_i[i*DW +: DW]    = d;
    endtask

    int nack;
    int m1acks;
    int order [3];

    initial begin
        bus.m_req_i     = '0;
        bus.m_we_i      = '0;
        bus.m_lock_i    = '0;
        bus.m_address_i = '0;
        bus.m_data_i    = '0;
        bus.s_data_i    = 32'hBAD0BAD0;
        repeat (2) @(posedge clk);
        #2;
        bus.m_req_i = 2'b10;
        #1;
        chk("rst_halt", bus.m_halt_o, 2'b10);
        chk("rst_grant", bus.grant_o, 0);
        chk("rst_s_addr", bus.s_address_o, 0);
        chk("rst_s_we", bus.s_we_o, 0);
        chk("rst_m_data", bus.m_data_o, 0);
        bus.m_req_i = '0;
        rst = 1'b0;

        // Master 0 write
        step();
        set_m(0, 1, 1, 0, 32'h10, 32'hDEADBEEF);
        #1 chk("t1_halt_c0", bus.m_halt_o, 2'b01);
        step();
        chk("t1_s_we_c1", bus.s_we_o, 1);
        chk("t1_s_addr_c1", bus.s_address_o, 32'h10);
        chk("t1_halt_c1", bus.m_halt_o, 2'b01);
        step();
        chk("t1_ack_c2", bus.m_ack_o, 2'b01);
        chk("t1_halt_c2", bus.m_halt_o, 2'b00);
        set_m(0, 0, 1, 0, 32'h10, 32'hDEADBEEF);
        step();
        chk("t1_grant_c3", bus.grant_o, 0);

        // Master 1 read, data valid only in cycle 3
        set_m(1, 1, 0, 0, 32'h20, 32'h0);
        step();
        chk("t2_grant_c1", bus.grant_o, 2'b10);
        chk("t2_s_addr_c1", bus.s_address_o, 32'h20);
        step();
        chk("t2_ack_c2", bus.m_ack_o, 0);
        step();
        bus.s_data_i = 32'h12345678;
        chk("t2_ack_c3", bus.m_ack_o, 0);
        step();
        chk("t2_ack_c4", bus.m_ack_o, 2'b10);
        chk("t2_m_data_c4", bus.m_data_o, 32'h12345678);
        chk("t2_s_we_c4", bus.s_we_o, 0);
        bus.s_data_i = 32'hBAD0BAD0;
        set_m(1, 0, 0, 0, 32'h20, 32'h0);
        step();

        // Both masters write continuously
        set_m(0, 1, 1, 0, 32'h100, 32'hA0);
        set_m(1, 1, 1, 0, 32'h200, 32'hB0);
        for (int c = 0; c < 12; c++) begin
            if (c > 0) step();
            chk("t3_ack", bus.m_ack_o,
                (c % 3 == 2) ? (((c / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00);
        end
        bus.m_req_i = '0;
        step();

        // Master 0 write so that round-robin alone would favour master 1 next
        set_m(0, 1, 1, 0, 32'h30, 32'h33);
        step();
        step();
        chk("t4_pre_ack", bus.m_ack_o, 2'b01);
        set_m(0, 0, 1, 0, 32'h30, 32'h33);
        step();

        // Reset in the middle of a master 1 read
        set_m(1, 1, 0, 0, 32'h40, 32'h77);
        step();
        chk("t4_grant_c1", bus.grant_o, 2'b10);
        step();
        #1 rst = 1'b1;
        #1;
        chk("t4_rst_grant", bus.grant_o, 0);
        chk("t4_rst_s_addr", bus.s_address_o, 0);
        chk("t4_rst_s_data", bus.s_data_o, 0);
        chk("t4_rst_m_data", bus.m_data_o, 0);
        chk("t4_rst_ack", bus.m_ack_o, 0);
        set_m(0, 1, 1, 0, 32'h50, 32'h55);
        set_m(1, 1, 1, 0, 32'h58, 32'h59);
        step();
        rst = 1'b0;
        step();
        chk("t4_post_rst_grant", bus.grant_o, 2'b01);
        step();
        chk("t4_post_rst_ack0", bus.m_ack_o, 2'b01);
        bus.m_req_i[0] = 1'b0;
        repeat (3) step();
        chk("t4_post_rst_ack1", bus.m_ack_o, 2'b10);
        bus.m_req_i[1] = 1'b0;
        step();

        // Master 1 two locked writes while master 0 waits
        set_m(1, 1, 1, 1, 32'h60, 32'h61);
        step();
        set_m(0, 1, 1, 0, 32'h70, 32'h71);
        nack   = 0;
        m1acks = 0;
        order  = '{-1, -1, -1};
        for (int c = 0; c < 20 && nack < 3; c++) begin
            step();
            if (bus.m_ack_o[0]) begin
                order[nack] = 0;
                nack++;
                bus.m_req_i[0] = 1'b0;
            end
            if (bus.m_ack_o[1]) begin
                order[nack] = 1;
                nack++;
                m1acks++;
                if (m1acks == 1) set_m(1, 1, 1, 1, 32'h64, 32'h65);
                else set_m(1, 0, 1, 0, 32'h64, 32'h65);
            end
        end
        chk("t5_ack_count", nack, 3);
        chk("t5_order0", order[0], 1);
`ifdef BUS_ARB_LOCK_EN
        chk("t5_order1", order[1], 1);
        chk("t5_order2", order[2], 0);
`else
        chk("t5_order1", order[1], 0);
        chk("t5_order2", order[2], 1);
`endif
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
`default_nettype wire
